// File: rtl/muldiv_unit_if.sv
// Execute-stage multiply/divide unit bus: operation request, HI/LO writes
// (mthi/mtlo) and the registered result/status returned to the pipeline.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, Signed, A, B, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, Signed, A, B, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply and divide into HI/LO, one bit per
// cycle on operand magnitudes, with sign correction applied in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_r;
  logic               neg_res;   // product / quotient must be negated
  logic               neg_a;     // remainder takes the dividend's sign
  logic               b_zero;    // divide with a zero divisor
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_hi;    // partial product high / remainder
  logic [WIDTH-1:0]   acc_lo;    // multiplier bits / quotient bits

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign a_neg = bus.Signed & bus.A[WIDTH-1];
  assign b_neg = bus.Signed & bus.B[WIDTH-1];
  // Negating the most negative value yields itself, which is the correct
  // unsigned magnitude 2^(WIDTH-1).
  assign a_mag = a_neg ? -bus.A : bus.A;
  assign b_mag = b_neg ? -bus.B : bus.B;

  // One shift-add or restoring-divide step on the shared accumulator.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (op_r) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction; with a zero divisor the remainder path reproduces A.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -acc_lo : acc_lo;
    rem_fix  = neg_a ? -acc_hi : acc_hi;
    if (op_r) begin
      fix_hi = rem_fix;
      fix_lo = b_zero ? '1 : quo_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      op_r            <= 1'b0;
      neg_res         <= 1'b0;
      neg_a           <= 1'b0;
      b_zero          <= 1'b0;
      opnd            <= '0;
      acc_hi          <= '0;
      acc_lo          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.hi_we) bus.hi <= bus.wdata;
          if (bus.lo_we) bus.lo <= bus.wdata;
          if (bus.start) begin
            state           <= S_RUN;
            cnt             <= '0;
            op_r            <= bus.op;
            neg_res         <= a_neg ^ b_neg;
            neg_a           <= a_neg;
            b_zero          <= bus.op & (bus.B == '0);
            opnd            <= bus.op ? b_mag : a_mag;
            acc_hi          <= '0;
            acc_lo          <= bus.op ? a_mag : b_mag;
            bus.busy        <= 1'b1;
            bus.div_by_zero <= 1'b0;
          end
        end
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          bus.hi          <= fix_hi;
          bus.lo          <= fix_lo;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          bus.div_by_zero <= b_zero;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, handshake guards,
// divide-by-zero and reset abort, all with hand-computed expectations.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for one edge (edge 0) and confirm acceptance.
  task automatic issue(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.Signed = s;
    bus.A      = a;
    bus.B      = b;
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("busy_at_accept", bus.busy, 1);
  endtask

  // Count edges until done, bounded; busy must hold until done rises.
  task automatic wait_done(input int first, output int lat);
    bit gap = 0;
    lat = first;
    while (!bus.done && lat < 200) begin
      tick();
      lat++;
      if (!bus.done && !bus.busy) gap = 1;
    end
    check("busy_held", gap, 0);
    check("busy_at_done", bus.busy, 0);
  endtask

  int lat;
  int pulses;

  initial begin
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.Signed = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = '0;
    reset      = 1'b1;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    reset = 1'b0;
    tick();

    // Unsigned FFFFFFFF * FFFFFFFF
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, lat);
    check("umul_latency", lat, 33);
    check("umul_hi", bus.hi, 32'hFFFF_FFFE);
    check("umul_lo", bus.lo, 32'h0000_0001);
    tick();
    check("done_one_cycle", bus.done, 0);

    // Signed -35 * 15, then back-to-back signed -7 / 2 from the done cycle
    issue(1'b0, 1'b1, -32'sd35, 32'd15);
    wait_done(0, lat);
    check("smul_latency", lat, 33);
    check("smul_hi", bus.hi, 32'hFFFF_FFFF);
    check("smul_lo", bus.lo, 32'hFFFF_FDF3);
    issue(1'b1, 1'b1, -32'sd7, 32'd2);
    check("b2b_done_drop", bus.done, 0);
    wait_done(0, lat);
    check("sdiv_latency", lat, 33);
    check("sdiv_lo", bus.lo, 32'hFFFF_FFFD);
    check("sdiv_hi", bus.hi, 32'hFFFF_FFFF);

    // Unsigned FFFFFFFF / 1
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(0, lat);
    check("udiv1_lo", bus.lo, 32'hFFFF_FFFF);
    check("udiv1_hi", bus.hi, 32'h0);
    check("udiv1_dbz", bus.div_by_zero, 0);

    // Signed most-negative / -1 wraps
    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, lat);
    check("sdivmin_lo", bus.lo, 32'h8000_0000);
    check("sdivmin_hi", bus.hi, 32'h0);
    check("sdivmin_dbz", bus.div_by_zero, 0);

    // Divide by zero
    issue(1'b1, 1'b0, 32'd5, 32'd0);
    wait_done(0, lat);
    check("dbz_latency", lat, 33);
    check("dbz_hi", bus.hi, 32'd5);
    check("dbz_lo", bus.lo, 32'hFFFF_FFFF);
    check("dbz_flag", bus.div_by_zero, 1);

    // Next start clears the flag; an HI write in the start cycle lands first
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_0777;
    issue(1'b0, 1'b0, 32'd3, 32'd4);
    check("dbz_clear", bus.div_by_zero, 0);
    check("write_with_start", bus.hi, 32'h0000_0777);
    wait_done(0, lat);
    check("mul34_hi", bus.hi, 32'h0);
    check("mul34_lo", bus.lo, 32'd12);

    // Idle writes
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_ABCD;
    tick();
    bus.lo_we = 1'b0;
    check("mtlo_lo", bus.lo, 32'h0000_ABCD);
    check("mtlo_hi_kept", bus.hi, 32'h0);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0055;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("both_hi", bus.hi, 32'h55);
    check("both_lo", bus.lo, 32'h55);

    // start and hi_we pulsed mid-RUN are ignored
    issue(1'b0, 1'b0, 32'd6, 32'd7);
    repeat (5) tick();
    bus.start  = 1'b1;
    bus.op     = 1'b1;
    bus.A      = 32'd100;
    bus.B      = 32'd0;
    bus.hi_we  = 1'b1;
    bus.wdata  = 32'h0000_1234;
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check("guard_hi_stable", bus.hi, 32'h55);
    wait_done(6, lat);
    check("guard_latency", lat, 33);
    check("guard_hi", bus.hi, 32'h0);
    check("guard_lo", bus.lo, 32'd42);
    check("guard_dbz", bus.div_by_zero, 0);

    // Reset at edge 10 of a multiply aborts it
    issue(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    check("abort_done", bus.done, 0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (bus.done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    issue(1'b0, 1'b1, 32'd9, 32'd9);
    wait_done(0, lat);
    check("post_abort_latency", lat, 33);
    check("post_abort_hi", bus.hi, 32'h0);
    check("post_abort_lo", bus.lo, 32'd81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
